// File: rtl/common_pkg.sv
// Shared definitions for the bus request path: data word width and queue state.
package common_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic {
    Idle = 1'b0,
    Busy = 1'b1
  } state_t;

endpackage

// File: rtl/bus_req_queue_if.sv
// Upstream write handshake and downstream head-word handshake of the request queue.
interface bus_req_queue_if
  import common_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // queue side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // producer / consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/bus_req_fifo_mem.sv
// Queue storage: write port, wrapping pointers and a registered head word.
// The caller guarantees no push while full and no pop while empty.
module bus_req_fifo_mem
  import common_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_rd_ptr_nxt = i_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
  assign o_rdata      = r_head;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Next head: the slot being written becomes the head only when nothing older remains.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (i_push && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = i_wdata;
  end

  // Registered head word, held while no push/pop changes it.
  always_ff @(posedge clk) begin
    if (!i_flush) r_head <= w_head_nxt;
  end

endmodule

// File: rtl/bus_req_queue.sv
// Bus request queue: handshake, occupancy and Idle/Busy FSM around bus_req_fifo_mem.
// Optional feature macro BUS_REQ_STATS_EN adds the saturating drop_cnt port.
module bus_req_queue
  import common_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  bus_req_queue_if.slave         bus,
  output state_t                 state,
  output logic [$clog2(DEPTH):0] count
`ifdef BUS_REQ_STATS_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_in_ready;
  logic          r_out_valid;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_push;
  logic          w_pop;

  assign w_push        = bus.in_valid && r_in_ready;
  assign w_pop         = r_out_valid && bus.out_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign count         = r_count;
  assign state         = r_state;

  // Next occupancy; flush wins over push and pop.
  always_comb begin
    w_count_nxt = r_count;
    if (flush)                w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  // Occupancy plus registered full/empty handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != CW'(DEPTH));
      r_out_valid <= (w_count_nxt != CW'(0));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= Idle;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: Busy while any entry is held.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      Idle: if (!flush && w_push) w_state_nxt = Busy;
      Busy: begin
        if (flush)                                               w_state_nxt = Idle;
        else if ((r_count == CW'(1)) && w_pop && !w_push)        w_state_nxt = Idle;
      end
      default: w_state_nxt = Idle;
    endcase
  end

  bus_req_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (bus.in_data),
    .o_rdata (bus.out_data)
  );

`ifdef BUS_REQ_STATS_EN
  logic [15:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  // Refused-push counter; saturates and survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     r_drop_cnt <= '0;
    else if (bus.in_valid && !r_in_ready && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bus_req_queue.sv
// Scoreboard bench for bus_req_queue: directed stimulus, decoupled negedge monitor.
module tb_bus_req_queue;
  import common_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  state_t        state;
  logic [CW-1:0] count;
`ifdef BUS_REQ_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  bus_req_queue_if #(.WIDTH(W)) bus ();

  bus_req_queue #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .state    (state),
    .count    (count)
`ifdef BUS_REQ_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          cnt;
    state_t      st;
    bit          vld;
    bit          rdy;
    bit          chk_data;
    logic [31:0] data;
    bit          chk_drop;
    logic [15:0] drop;
  } dir_t;

  dir_t        dir_q[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_cnt   = 0;
`ifdef BUS_REQ_STATS_EN
  int          m_drop  = 0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: directed expectations first, then the running scoreboard model.
  always @(negedge clk) begin : monitor
    dir_t d;
    bit   pop_e;
    bit   push_e;
    if (dir_q.size() != 0) begin
      d = dir_q.pop_front();
      chk($sformatf("dir%0d.count", d.tag), 32'(count), 32'(d.cnt));
      chk($sformatf("dir%0d.state", d.tag), 32'(state), 32'(d.st));
      chk($sformatf("dir%0d.out_valid", d.tag), 32'(bus.out_valid), 32'(d.vld));
      chk($sformatf("dir%0d.in_ready", d.tag), 32'(bus.in_ready), 32'(d.rdy));
      if (d.chk_data) chk($sformatf("dir%0d.out_data", d.tag), bus.out_data, d.data);
`ifdef BUS_REQ_STATS_EN
      if (d.chk_drop) chk($sformatf("dir%0d.drop_cnt", d.tag), 32'(drop_cnt), 32'(d.drop));
`endif
    end
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
`ifdef BUS_REQ_STATS_EN
      m_drop = 0;
`endif
    end else begin
      chk("mon.count", 32'(count), 32'(m_cnt));
      chk("mon.in_ready", 32'(bus.in_ready), (m_cnt != DEPTH) ? 32'd1 : 32'd0);
      chk("mon.out_valid", 32'(bus.out_valid), (m_cnt != 0) ? 32'd1 : 32'd0);
      chk("mon.state", 32'(state), (m_cnt != 0) ? 32'(Busy) : 32'(Idle));
`ifdef BUS_REQ_STATS_EN
      chk("mon.drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (bus.in_valid && (m_cnt == DEPTH) && (m_drop != 32'hFFFF)) m_drop++;
`endif
      if (flush) begin
        exp_q.delete();
        m_cnt = 0;
      end else begin
        pop_e  = (m_cnt != 0) && bus.out_ready;
        push_e = bus.in_valid && (m_cnt != DEPTH);
        if (pop_e) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon.pop_empty actual=%0h required=none", bus.out_data);
          end else begin
            chk("mon.out_data", bus.out_data, exp_q.pop_front());
          end
        end
        if (push_e) exp_q.push_back(bus.in_data);
        m_cnt = m_cnt + int'(push_e) - int'(pop_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int tag, input int cnt, input state_t st, input bit vld,
                        input bit rdy, input bit chkd, input logic [31:0] data,
                        input bit chkdrop = 1'b0, input logic [15:0] drop = 16'h0);
    dir_t d;
    d.tag = tag; d.cnt = cnt; d.st = st; d.vld = vld; d.rdy = rdy;
    d.chk_data = chkd; d.data = data; d.chk_drop = chkdrop; d.drop = drop;
    dir_q.push_back(d);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    exp_at(1, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 16'h0);
    step();
    rst = 1'b0;
    step();

    // single push, one-cycle latency, stall stability, pop
    bus.in_valid = 1'b1;
    bus.in_data = 32'hA5A5_0001;
    exp_at(2, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    exp_at(3, 1, Busy, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
    step();
    exp_at(4, 1, Busy, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_at(5, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0);

    // fill, refused push while full, drain in order
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'(i);
      step();
    end
    exp_at(6, 4, Busy, 1'b1, 1'b0, 1'b1, 32'd1, 1'b1, 16'd0);
    bus.in_data = 32'd5;
    step();
    exp_at(7, 4, Busy, 1'b1, 1'b0, 1'b1, 32'd1, 1'b1, 16'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    exp_at(8, 3, Busy, 1'b1, 1'b1, 1'b1, 32'd2);
    step();
    exp_at(9, 2, Busy, 1'b1, 1'b1, 1'b1, 32'd3);
    step();
    exp_at(10, 1, Busy, 1'b1, 1'b1, 1'b1, 32'd4);
    step();
    exp_at(11, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 16'd1);
    bus.out_ready = 1'b0;

    // steady streaming
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data = 32'd0;
    step();
    exp_at(12, 1, Busy, 1'b1, 1'b1, 1'b1, 32'd0);
    for (int i = 1; i < 20; i++) begin
      bus.in_data = 32'(i);
      step();
      exp_at(100 + i, 1, Busy, 1'b1, 1'b1, 1'b1, 32'(i));
    end
    bus.in_valid = 1'b0;
    step();
    exp_at(13, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0);
    bus.out_ready = 1'b0;

    // flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'(10 + i);
      step();
    end
    exp_at(14, 3, Busy, 1'b1, 1'b1, 1'b1, 32'd10);
    flush = 1'b1;
    bus.in_data = 32'd13;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    exp_at(15, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0);

    // async reset in the middle of a pop sequence
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'(20 + i);
      step();
    end
    bus.in_valid = 1'b0;
    exp_at(16, 2, Busy, 1'b1, 1'b1, 1'b1, 32'd20);
    bus.out_ready = 1'b1;
    step();
    rst = 1'b1;
    exp_at(17, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    step();
    exp_at(18, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 16'd0);
    bus.in_valid = 1'b1;
    bus.in_data = 32'd30;
    step();
    bus.in_valid = 1'b0;
    exp_at(19, 1, Busy, 1'b1, 1'b1, 1'b1, 32'd30);
    step();
    exp_at(20, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0);
    bus.out_ready = 1'b0;

`ifdef BUS_REQ_STATS_EN
    // drop counter saturation, untouched by flush
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 32'(40 + i);
      step();
    end
    bus.in_data = 32'd44;
    repeat (70000) step();
    exp_at(21, 4, Busy, 1'b1, 1'b0, 1'b1, 32'd40, 1'b1, 16'hFFFF);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_at(22, 0, Idle, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 16'hFFFF);
`endif

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_req_queue.md
BUS_REQ_QUEUE -- requirements
Module: bus_req_queue

Interface
REQ-001 Parameter: WIDTH, default common_pkg::DATA_WIDTH, width of the data word.
REQ-002 Parameter: DEPTH, default 4, number of FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of all queued entries.
REQ-006 in_valid  input  1  upstream has a word on in_data.
REQ-007 in_ready  output  1  queue can accept a word this cycle.
REQ-008 in_data  input  WIDTH  upstream write data.
REQ-009 out_valid  output  1  head word is available to the bus_intf stage.
REQ-010 out_ready  input  1  bus_intf stage accepts the head word.
REQ-011 out_data  output  WIDTH  head word.
REQ-012 state  output  common_pkg::state_t  Idle when empty, Busy otherwise.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 drop_cnt  output  16  count of attempted pushes refused while full; present only with BUS_REQ_STATS_EN.

Function
REQ-015 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL be (count != DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-017 out_valid SHALL be (count != 0); out_data SHALL be the registered head entry, not a mux fed by in_data.
REQ-018 Latency: a word pushed in cycle N SHALL first show on out_valid in cycle N+1 when the queue was empty.
REQ-019 Order SHALL be strict FIFO.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and SHALL be legal when full (pop frees the slot in the same cycle only if no combinational path is added; otherwise in_ready=0 when full, and the push is refused).
REQ-022 FSM state SHALL be registered. Idle->Busy on push with count==0. Busy->Idle when count==1 with pop and no push, or on flush.
REQ-023 flush SHALL take priority over push and pop in the same cycle. Next cycle: count=0, state=Idle, out_valid=0.
REQ-024 out_data and out_valid SHALL remain stable while out_valid && !out_ready.

Reset
REQ-025 While rst=1: pointers=0, count=0, state=Idle, out_valid=0, in_ready=1, drop_cnt=0. Storage contents SHALL be left un-reset.
REQ-026 Reset asserted mid-transfer SHALL discard all entries immediately; no pop SHALL be reported after deassertion.

Configuration
REQ-027 With macro BUS_REQ_STATS_EN defined, the drop_cnt port and logic SHALL exist: it increments when in_valid && !in_ready, saturates at 16'hFFFF, and is not cleared by flush.
REQ-028 Without BUS_REQ_STATS_EN, the drop_cnt port and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 DATA_WIDTH and state_t {Idle, Busy} SHALL come from common_pkg; no local redefinition is allowed.
REQ-030 Storage and pointers SHALL live in one sub-module, bus_req_fifo_mem (write port plus registered read-head); the FSM and handshake SHALL live in bus_req_queue.

Verification
REQ-031 Reset then push 32'hA5A5_0001 with out_ready=0 -> next cycle out_valid=1, out_data=32'hA5A5_0001, state=Busy, count=1.
REQ-032 Push 4 words 1..4 with out_ready=0, then in_valid=1 with 5 -> in_ready=0, count=4, drop_cnt=1 (stats on); then pop all -> outputs 1,2,3,4 in order, state=Idle.
REQ-033 Steady streaming: in_valid=out_ready=1 for 20 cycles with values 0..19 -> count constant at 1, values out in order, no bubbles after the first cycle.
REQ-034 Fill to 3 entries, then flush=1 together with a push and a pop -> next cycle count=0, out_valid=0, state=Idle.
REQ-035 With 2 entries queued, assert rst for 1 cycle mid-pop -> out_valid=0 and count=0 immediately; the first push after reset is returned first.
REQ-036 Hold in_valid=1 while full for 70000 cycles (stats on) -> drop_cnt saturates at 16'hFFFF; compiled without the macro -> the drop_cnt port does not exist.
